fb_ctrl: RTL and testbench
==========================

# fb_ctrl

Parametrised framebuffer store with a CPU access port, a hardware clear engine, and a backpressured scanout stream. It replaces the fixed 256x8 single-port framebuffer RAM. It sits between the CPU bus (pixel pokes and peeks) and the display pipeline (a linear pixel stream with valid/ready). Memory is one simple-dual-port array: one write port and one read port.

## Interface
- DATA_W, 8: pixel width in bits
- ADDR_W, 8: address width; DEPTH = 2**ADDR_W pixels
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- cpu_we  in  1  write strobe for cpu_addr/cpu_din
- cpu_re  in  1  read strobe for cpu_addr
- cpu_addr  in  ADDR_W  CPU pixel address
- cpu_din  in  DATA_W  CPU write data
- cpu_dout  out  DATA_W  CPU read data; holds until the next CPU read
- cpu_rvalid  out  1  one-cycle pulse, cpu_dout updated
- cpu_wr_drop  out  1  one-cycle pulse, a CPU write was discarded because a clear was in progress
- clr_start  in  1  start a fill of the whole buffer
- clr_value  in  DATA_W  fill value, sampled on the accepted clr_start
- clr_busy  out  1  clear in progress
- scan_start  in  1  start one full-frame scanout
- scan_busy  out  1  scanout in progress
- px_data  out  DATA_W  pixel data
- px_valid  out  1  px_data valid
- px_ready  in  1  sink accepts the pixel when px_valid && px_ready
- px_last  out  1  marks address DEPTH-1; valid only with px_valid

## Operation
- Memory contents are not reset. Every port output and every state register resets to 0 / IDLE.
- **Write port**
  - While clr_busy=1 the write port belongs to the clear engine.
  - Otherwise cpu_we writes the pixel.
  - A cpu_we during a clear is dropped and pulses cpu_wr_drop on the next cycle.
- **Read port**
  - cpu_re has priority.
  - The scan engine issues no read in any cycle where cpu_re=1.
  - A read at the same address as a same-cycle write returns the old data (read-first).
- **Clear FSM** (C_IDLE, C_RUN)
  - In C_IDLE, clr_start latches clr_value and moves to C_RUN with clear address 0.
  - C_RUN writes one address per cycle from 0 to DEPTH-1, then returns to C_IDLE.
  - clr_start is ignored while in C_RUN.
- **Scan FSM** (S_IDLE, S_RUN, S_DRAIN)
  - In S_IDLE, scan_start moves to S_RUN with scan address 0.
  - S_RUN issues a read when the read port is free and the 2-entry output buffer will have a free slot next cycle, counting reads already in flight.
  - After address DEPTH-1 has been issued, the FSM moves to S_DRAIN.
  - S_DRAIN moves to S_IDLE on the handshake of the px_last pixel.
  - scan_start is ignored while not in S_IDLE.
- **Output buffer**
  - The output buffer is a 2-entry FIFO of {data, last} that drives px_*.
  - px_data and px_valid are stable while px_valid && !px_ready.
- No coherency between clear and scan: a scan that runs during a clear returns whatever each address holds at its read cycle.
- clr_start and scan_start in the same cycle: both engines start.
- Address counters are ADDR_W bits and stop at DEPTH-1; they never wrap within one operation.

## Timing
- CPU read: cpu_re at cycle N gives cpu_dout and cpu_rvalid=1 at N+1.
- CPU write: visible to a read issued at N+1 or later.
- Clear:
  - clr_start at N gives clr_busy=1 from N+1.
  - Writes occur at N+1 .. N+DEPTH.
  - clr_busy=0 at N+DEPTH+1.
- Scan:
  - scan_start at N gives scan_busy=1 from N+1.
  - The first read is issued at N+1; the first px_valid is at N+2.
  - With px_ready=1 and no cpu_re, throughput is 1 pixel/cycle.
  - px_last is seen at N+DEPTH+1.
  - scan_busy=0 the cycle after the px_last handshake.
- Each cpu_re during a scan delays the stream by exactly one cycle.
- Reset mid-operation:
  - Both FSMs abort to IDLE and the output buffer is emptied.
  - Outputs are 0 the cycle after rst.
  - Memory keeps any partial clear.

## Test plan
- Reset then CPU access: write 0xA5 at address 0x10, read 0x10 the next cycle -> cpu_rvalid=1 and cpu_dout=0xA5 one cycle after cpu_re. Same-cycle write 0x3C and read at 0x10 -> cpu_dout=0xA5 (old data).
- Clear: clr_start with clr_value=0x7E -> clr_busy high for exactly 256 cycles. Then reading addresses 0x00, 0x80, 0xFF returns 0x7E. A cpu_we mid-clear -> cpu_wr_drop pulse and the target address still holds 0x7E.
- Scan, full rate: memory preloaded with addr^0x55, scan_start, px_ready=1 -> 256 beats in 256 consecutive cycles starting 2 cycles after start, data = i^0x55, px_last only on beat 255.
- Backpressure: random px_ready at 30% high plus random cpu_re -> all 256 beats in order with no loss or duplication, and px_data stable while stalled.
- Start collisions: clr_start during a clear and scan_start during a scan are ignored (busy widths unchanged). Simultaneous starts -> both engines complete.
- Reset mid-scan at beat 100 -> px_valid=0 and scan_busy=0 the next cycle. A new scan_start then streams from address 0.

Source files
------------

// File: rtl/fb_ctrl.sv
// fb_ctrl: framebuffer store with CPU port, clear engine and backpressured scanout
module fb_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_we,
  input  logic              cpu_re,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_rvalid,
  output logic              cpu_wr_drop,
  input  logic              clr_start,
  input  logic [DATA_W-1:0] clr_value,
  output logic              clr_busy,
  input  logic              scan_start,
  output logic              scan_busy,
  output logic [DATA_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_last
);
  localparam int DEPTH = 2**ADDR_W;
  typedef enum logic {C_IDLE, C_RUN} c_state_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} s_state_e;
  c_state_e c_q;
  s_state_e s_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] clr_addr_q, scan_addr_q, waddr, raddr;
  logic [DATA_W-1:0] clr_val_q, cpu_dout_q, wdata, rdata;
  logic [DATA_W-1:0] fd_q [2];
  logic [1:0]        fl_q, cnt_q, cnt_d;
  logic              wp_q, rp_q, cpu_rvalid_q, cpu_wr_drop_q, we, issue, pop;
  assign clr_busy    = c_q == C_RUN;
  assign scan_busy   = s_q != S_IDLE;
  assign px_valid    = cnt_q != 2'd0;
  assign px_data     = fd_q[rp_q];
  assign px_last     = px_valid & fl_q[rp_q];
  assign cpu_dout    = cpu_dout_q;
  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_wr_drop = cpu_wr_drop_q;
  always_comb begin
    we    = clr_busy | cpu_we;
    waddr = clr_busy ? clr_addr_q : cpu_addr;
    wdata = clr_busy ? clr_val_q : cpu_din;
    raddr = cpu_re ? cpu_addr : scan_addr_q;
    rdata = mem[raddr];
    pop   = px_valid & px_ready;
    issue = s_q == S_RUN && !cpu_re && (cnt_q != 2'd2 || pop);
    cnt_d = cnt_q + 2'(issue) - 2'(pop);
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q           <= C_IDLE;
      s_q           <= S_IDLE;
      clr_addr_q    <= '0;
      scan_addr_q   <= '0;
      clr_val_q     <= '0;
      cpu_dout_q    <= '0;
      cpu_rvalid_q  <= 1'b0;
      cpu_wr_drop_q <= 1'b0;
      fd_q          <= '{default: '0};
      fl_q          <= '0;
      wp_q          <= 1'b0;
      rp_q          <= 1'b0;
      cnt_q         <= '0;
    end else begin
      cpu_rvalid_q  <= cpu_re;
      cpu_wr_drop_q <= cpu_we & clr_busy;
      if (cpu_re) cpu_dout_q <= rdata;
      if (c_q == C_IDLE) begin
        if (clr_start) begin
          c_q        <= C_RUN;
          clr_addr_q <= '0;
          clr_val_q  <= clr_value;
        end
      end else if (&clr_addr_q) c_q <= C_IDLE;
      else clr_addr_q <= clr_addr_q + ADDR_W'(1);
      if (s_q == S_IDLE && scan_start) begin
        s_q         <= S_RUN;
        scan_addr_q <= '0;
      end
      if (issue) begin
        fd_q[wp_q] <= rdata;
        fl_q[wp_q] <= &scan_addr_q;
        wp_q       <= ~wp_q;
        if (&scan_addr_q) s_q <= S_DRAIN;
        else scan_addr_q <= scan_addr_q + ADDR_W'(1);
      end
      if (pop) rp_q <= ~rp_q;
      if (s_q == S_DRAIN && pop && fl_q[rp_q]) s_q <= S_IDLE;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_fb_ctrl.sv
// tb_fb_ctrl: directed self-checking bench for fb_ctrl
module tb_fb_ctrl;
  logic       clk = 0, rst = 1, cpu_we = 0, cpu_re = 0, clr_start = 0, scan_start = 0, px_ready = 0;
  logic [7:0] cpu_addr = 0, cpu_din = 0, clr_value = 0;
  logic [7:0] cpu_dout, px_data;
  logic       cpu_rvalid, cpu_wr_drop, clr_busy, scan_busy, px_valid, px_last;
  int checks = 0, failures = 0;
  fb_ctrl #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_rvalid(cpu_rvalid), .cpu_wr_drop(cpu_wr_drop),
    .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
    .scan_start(scan_start), .scan_busy(scan_busy), .px_data(px_data), .px_valid(px_valid),
    .px_ready(px_ready), .px_last(px_last)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    cpu_we = 1; cpu_addr = a; cpu_din = d;
    step();
    cpu_we = 0;
  endtask
  task automatic do_read(input logic [7:0] a, output logic [7:0] d, output logic v);
    cpu_re = 1; cpu_addr = a;
    step();
    cpu_re = 0; d = cpu_dout; v = cpu_rvalid;
  endtask
  task automatic test_reset();
    rst = 1; step(); step(); rst = 0;
    checks++;
    if ({cpu_dout, cpu_rvalid, cpu_wr_drop, clr_busy, scan_busy, px_data, px_valid, px_last} !== 22'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0", {cpu_dout, cpu_rvalid, cpu_wr_drop, clr_busy, scan_busy, px_data, px_valid, px_last});
    end
  endtask
  task automatic test_cpu();
    logic [7:0] d;
    logic v;
    do_write(8'h10, 8'hA5);
    do_read(8'h10, d, v);
    checks++;
    if (v !== 1'b1 || d !== 8'hA5) begin failures++; $display("FAIL cpu_read rvalid=%b dout=%h expected 1/a5", v, d); end
    step();
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_dout !== 8'hA5) begin failures++; $display("FAIL cpu_hold rvalid=%b dout=%h expected 0/a5", cpu_rvalid, cpu_dout); end
    cpu_we = 1; cpu_re = 1; cpu_addr = 8'h10; cpu_din = 8'h3C;
    step();
    cpu_we = 0; cpu_re = 0;
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_dout !== 8'hA5) begin failures++; $display("FAIL read_first rvalid=%b dout=%h expected 1/a5", cpu_rvalid, cpu_dout); end
    do_read(8'h10, d, v);
    checks++;
    if (d !== 8'h3C) begin failures++; $display("FAIL cpu_write_visible dout=%h expected 3c", d); end
  endtask
  task automatic test_clear();
    int n = 0;
    logic [7:0] d, addrs[4];
    logic v;
    addrs = '{8'h00, 8'h80, 8'hFF, 8'h20};
    clr_value = 8'h7E; clr_start = 1;
    step();
    clr_start = 0;
    while (clr_busy && n < 400) begin
      n++;
      if (n == 50) begin cpu_we = 1; cpu_addr = 8'h20; cpu_din = 8'h11; end
      step();
      if (n == 50) begin
        cpu_we = 0;
        checks++;
        if (cpu_wr_drop !== 1'b1) begin failures++; $display("FAIL clr_wr_drop got=%b expected 1", cpu_wr_drop); end
      end
    end
    checks++;
    if (n != 256) begin failures++; $display("FAIL clr_busy_width got=%0d expected 256", n); end
    checks++;
    if (cpu_wr_drop !== 1'b0) begin failures++; $display("FAIL wr_drop_idle got=%b expected 0", cpu_wr_drop); end
    foreach (addrs[i]) begin
      do_read(addrs[i], d, v);
      checks++;
      if (d !== 8'h7E) begin failures++; $display("FAIL clr_value addr=%h got=%h expected 7e", addrs[i], d); end
    end
  endtask
  task automatic test_scan_full();
    for (int a = 0; a < 256; a++) do_write(8'(a), 8'(a) ^ 8'h55);
    px_ready = 1; scan_start = 1;
    step();
    scan_start = 0;
    checks++;
    if (scan_busy !== 1'b1 || px_valid !== 1'b0) begin failures++; $display("FAIL scan_first busy=%b valid=%b expected 1/0", scan_busy, px_valid); end
    step();
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (px_valid !== 1'b1 || px_data !== (8'(i) ^ 8'h55) || px_last !== (i == 255)) begin
        failures++;
        $display("FAIL scan_beat %0d valid=%b data=%h last=%b expected 1/%h/%b", i, px_valid, px_data, px_last, 8'(i) ^ 8'h55, i == 255);
      end
      step();
    end
    checks++;
    if (scan_busy !== 1'b0 || px_valid !== 1'b0) begin failures++; $display("FAIL scan_end busy=%b valid=%b expected 0/0", scan_busy, px_valid); end
  endtask
  task automatic test_backpressure();
    int exp_i = 0, cyc = 0;
    logic stall = 0, rd_pend = 0;
    logic [7:0] held = 0, ra = 0;
    scan_start = 1;
    step();
    scan_start = 0;
    while (exp_i < 256 && cyc < 5000) begin
      if (stall) begin
        checks++;
        if (px_valid !== 1'b1 || px_data !== held) begin failures++; $display("FAIL bp_stall valid=%b data=%h expected 1/%h", px_valid, px_data, held); end
      end
      if (rd_pend) begin
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_dout !== (ra ^ 8'h55)) begin failures++; $display("FAIL bp_cpu_read rvalid=%b dout=%h expected 1/%h", cpu_rvalid, cpu_dout, ra ^ 8'h55); end
      end
      px_ready = ($urandom_range(0, 99) < 30);
      rd_pend = ($urandom_range(0, 3) == 0);
      ra = 8'($urandom_range(0, 255));
      cpu_re = rd_pend; cpu_addr = ra;
      if (px_valid && px_ready) begin
        checks++;
        if (px_data !== (8'(exp_i) ^ 8'h55) || px_last !== (exp_i == 255)) begin
          failures++;
          $display("FAIL bp_beat %0d data=%h last=%b expected %h/%b", exp_i, px_data, px_last, 8'(exp_i) ^ 8'h55, exp_i == 255);
        end
        exp_i++;
      end
      stall = px_valid && !px_ready;
      held = px_data;
      step();
      cyc++;
    end
    cpu_re = 0; px_ready = 1;
    checks++;
    if (exp_i != 256) begin failures++; $display("FAIL bp_beats got=%0d expected 256", exp_i); end
    checks++;
    if (scan_busy !== 1'b0 || px_valid !== 1'b0) begin failures++; $display("FAIL bp_end busy=%b valid=%b expected 0/0", scan_busy, px_valid); end
  endtask
  task automatic test_cpu_delay();
    int k = 1;
    px_ready = 1; scan_start = 1;
    step();
    scan_start = 0;
    while (!(px_valid && px_last) && k < 400) begin
      cpu_re = (k == 10 || k == 20 || k == 21); cpu_addr = 8'h00;
      step();
      k++;
    end
    cpu_re = 0;
    checks++;
    if (k != 260) begin failures++; $display("FAIL cpu_re_delay last_at=%0d expected 260", k); end
    step();
    checks++;
    if (scan_busy !== 1'b0) begin failures++; $display("FAIL delay_busy_end got=%b expected 0", scan_busy); end
  endtask
  task automatic test_reset_mid_scan();
    int b = 0, k = 0;
    px_ready = 1; scan_start = 1;
    step();
    scan_start = 0;
    while (b < 100 && k < 400) begin
      if (px_valid) b++;
      step();
      k++;
    end
    rst = 1;
    step();
    rst = 0;
    checks++;
    if ({scan_busy, px_valid, px_last, px_data, clr_busy} !== 12'h0) begin
      failures++;
      $display("FAIL mid_reset busy=%b valid=%b last=%b data=%h expected all 0", scan_busy, px_valid, px_last, px_data);
    end
    step();
    scan_start = 1;
    step();
    scan_start = 0;
    step();
    checks++;
    if (px_valid !== 1'b1 || px_data !== 8'h55) begin failures++; $display("FAIL rescan_beat0 valid=%b data=%h expected 1/55", px_valid, px_data); end
    step();
    checks++;
    if (px_valid !== 1'b1 || px_data !== 8'h54) begin failures++; $display("FAIL rescan_beat1 valid=%b data=%h expected 1/54", px_valid, px_data); end
    k = 0;
    while (scan_busy && k < 400) begin step(); k++; end
  endtask
  task automatic test_collisions();
    int n = 0, k = 1;
    logic [7:0] d;
    logic v;
    clr_value = 8'h33; clr_start = 1;
    step();
    clr_start = 0;
    while (clr_busy && n < 400) begin
      n++;
      if (n == 10) begin clr_start = 1; clr_value = 8'h99; end
      step();
      clr_start = 0;
    end
    checks++;
    if (n != 256) begin failures++; $display("FAIL clr_restart_width got=%0d expected 256", n); end
    do_read(8'hFF, d, v);
    checks++;
    if (d !== 8'h33) begin failures++; $display("FAIL clr_restart_value got=%h expected 33", d); end
    px_ready = 1; scan_start = 1;
    step();
    scan_start = 0;
    while (!(px_valid && px_last) && k < 400) begin
      scan_start = (k == 50);
      step();
      k++;
    end
    scan_start = 0;
    checks++;
    if (k != 257) begin failures++; $display("FAIL scan_restart last_at=%0d expected 257", k); end
    step();
    step();
    checks++;
    if (scan_busy !== 1'b0) begin failures++; $display("FAIL scan_restart_end busy=%b expected 0", scan_busy); end
  endtask
  task automatic test_back_to_back();
    int nc = 0, beats = 0, bad = 0, t = 0;
    logic [7:0] d;
    logic v;
    clr_value = 8'h44; clr_start = 1; scan_start = 1; px_ready = 1;
    step();
    clr_start = 0; scan_start = 0;
    while ((clr_busy || scan_busy) && t < 600) begin
      if (clr_busy) nc++;
      if (px_valid && px_ready) begin
        if (px_data !== 8'h33) bad++;
        beats++;
      end
      step();
      t++;
    end
    checks++;
    if (nc != 256 || beats != 256) begin failures++; $display("FAIL both_start clr_width=%0d beats=%0d expected 256/256", nc, beats); end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL both_start_data wrong_beats=%0d expected 0", bad); end
    do_read(8'h80, d, v);
    checks++;
    if (d !== 8'h44) begin failures++; $display("FAIL both_start_mem got=%h expected 44", d); end
  endtask
  initial begin
    test_reset();
    test_cpu();
    test_clear();
    test_scan_full();
    test_backpressure();
    test_cpu_delay();
    test_reset_mid_scan();
    test_collisions();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
